// File: rtl/detector_borda_multi.sv
// Multi-channel edge detector: synchroniser, optional debounce filter, edge select, sticky flags, saturating count.
// Optional debounce filter is compiled in with `define DETECTOR_BORDA_DEBOUNCE_EN.
module detector_borda_multi #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     entrada,
    input  logic [1:0]       modo,
    input  logic [N-1:0]     limpa,
    input  logic             zera_cont,
    output logic [N-1:0]     detector,
    output logic [N-1:0]     pendente,
    output logic [CNT_W-1:0] contagem
);

    localparam int PW = $clog2(N + 1);
    localparam int SW = CNT_W + PW;

    logic [N-1:0]     r_sync [SYNC_STAGES];
    logic [N-1:0]     w_sinc;
    logic [N-1:0]     w_estavel;
    logic [N-1:0]     r_anterior;
    logic [N-1:0]     w_rise;
    logic [N-1:0]     w_fall;
    logic [N-1:0]     w_det_n;
    logic [PW-1:0]    w_pop;
    logic [SW-1:0]    w_sum;
    logic [CNT_W-1:0] w_cont_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= entrada;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sinc = r_sync[SYNC_STAGES-1];

`ifdef DETECTOR_BORDA_DEBOUNCE_EN
    localparam int DCW = $clog2(DEBOUNCE + 1);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_deb
            logic [DCW-1:0] r_cont;
            logic           r_estavel;

            // A new level is accepted only after DEBOUNCE consecutive mismatching samples.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cont    <= '0;
                    r_estavel <= 1'b0;
                end else if (w_sinc[gi] == r_estavel) begin
                    r_cont <= '0;
                end else if (r_cont == DCW'(DEBOUNCE - 1)) begin
                    r_estavel <= w_sinc[gi];
                    r_cont    <= '0;
                end else begin
                    r_cont <= r_cont + 1'b1;
                end
            end

            assign w_estavel[gi] = r_estavel;
        end
    endgenerate
`else
    assign w_estavel = w_sinc;

    // DEBOUNCE has no effect without the filter; kept for a uniform parameter list.
    generate
        if (DEBOUNCE < 1) begin : g_debounce_unused
        end
    endgenerate
`endif

    always_comb begin
        w_rise = w_estavel & ~r_anterior;
        w_fall = ~w_estavel & r_anterior;
        case (modo)
            2'b00:   w_det_n = w_rise;
            2'b01:   w_det_n = w_fall;
            2'b10:   w_det_n = w_rise | w_fall;
            default: w_det_n = '0;
        endcase
    end

    // Widened sum so several simultaneous events can never wrap before saturation.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < N; k++) begin
            w_pop = w_pop + PW'(w_det_n[k]);
        end
        w_sum       = {{PW{1'b0}}, contagem} + SW'(w_pop);
        w_cont_next = (|w_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_anterior <= '0;
            detector   <= '0;
            pendente   <= '0;
            contagem   <= '0;
        end else begin
            r_anterior <= w_estavel;
            detector   <= w_det_n;
            pendente   <= w_det_n | (pendente & ~limpa);
            contagem   <= zera_cont ? '0 : w_cont_next;
        end
    end

endmodule

// File: doc/detector_borda_multi.md
# detector_borda_multi

Parametrised multi-channel edge detector: the successor to the fixed 2-bit edge detector. Each of N asynchronous input lines is synchronised, optionally debounced, and checked for a selectable edge type. Qualifying edges produce a one-cycle pulse, a sticky per-channel pending flag and a saturating aggregate event count. The block sits between raw external inputs (buttons, strobes) and control logic that polls or reacts to events.

## Interface
- `N`, default 2: number of channels, ≥1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel, ≥1.
- `DEBOUNCE`, default 4: consecutive cycles a new level must persist before it is accepted, ≥1. Used only when debounce is compiled in.
- `CNT_W`, default 8: width of the event counter, ≥1.

- `clk`  in  1: single clock, rising-edge active.
- `rst`  in  1: asynchronous, active-low reset.
- `entrada`  in  N: raw input lines, asynchronous to `clk`.
- `modo`  in  2: edge select for all channels. 00 = rising, 01 = falling, 10 = both, 11 = disabled.
- `limpa`  in  N: per-channel clear for `pendente`.
- `zera_cont`  in  1: synchronous clear of `contagem`.
- `detector`  out  N: one-cycle pulse per qualifying edge.
- `pendente`  out  N: sticky flag, set by an edge and held until cleared.
- `contagem`  out  CNT_W: saturating total of detected edges.

## Operation
- **Reset.** While `rst`=0, every flop clears to 0: sync chain, `estavel`, `anterior`, debounce counters, `detector`, `pendente` and `contagem`.
- **Synchroniser.** Each channel runs through a `SYNC_STAGES` flop chain. Its output is `sinc[i]`.
- **Filtered level `estavel[i]`.**
  - With debounce: see Configuration.
  - Without debounce: `estavel[i]` = `sinc[i]`.
- **Edge history.** `anterior[i]` <= `estavel[i]` every cycle.
- **Edge terms.**
  - rise = `estavel` & ~`anterior`.
  - fall = ~`estavel` & `anterior`.
- **Next detector value `det_n[i]`.** Selected by `modo`:
  - 00: rise.
  - 01: fall.
  - 10: rise | fall.
  - 11: 0.
- **Registered outputs.**
  - `detector` <= `det_n`.
  - `modo` is not pipelined. It applies to the edge evaluated on the same clock.
  - The filter and history keep tracking in mode 11, so re-enabling produces no spurious edge.
- **Pending flags.**
  - `pendente[i]` <= `det_n[i]` | (`pendente[i]` & ~`limpa[i]`).
  - If an edge and `limpa` arrive on the same cycle, set wins.
- **Event counter.**
  - `contagem` <= `zera_cont` ? 0 : min(`contagem` + popcount(`det_n`), 2^CNT_W−1).
  - The addition is done at CNT_W+clog2(N+1) bits before saturating, so it never wraps.
  - `zera_cont` wins over events on the same cycle; those events are not counted.
- **Input high at reset release.** Because the filter resets to 0, an input already high when reset is released reports a rising edge once it propagates through the pipeline.

## Timing
- Edge E0 is the first `clk` edge that samples the new `entrada` level.
- **Without debounce.** `detector` is high in the cycle after edge E(SYNC_STAGES), i.e. SYNC_STAGES+1 edges of latency (default 3). `pendente` sets and `contagem` updates on the same edge.
- **With debounce.**
  - `estavel` updates at edge E(SYNC_STAGES+DEBOUNCE−1).
  - `detector` pulses after edge E(SYNC_STAGES+DEBOUNCE).
  - Latency is SYNC_STAGES+DEBOUNCE+1 edges (default 7).
- **Pulse width.** `detector` is exactly one cycle per accepted transition.
- **Back-to-back edges.** Without debounce, edges can occur on consecutive cycles, giving one pulse each. Mode 10 on a toggling input pulses every cycle.
- **Reset mid-operation.** Asserting reset takes effect immediately (asynchronous) and discards any in-flight edge. Release is expected synchronous to `clk` upstream.

## Configuration
- Macro: `DETECTOR_BORDA_DEBOUNCE_EN`.
- **Defined.** Each channel has a clog2(DEBOUNCE+1)-bit counter `cont[i]`.
  - If `sinc[i]` == `estavel[i]`: `cont[i]` <= 0.
  - Else if `cont[i]` == DEBOUNCE−1: `estavel[i]` <= `sinc[i]` and `cont[i]` <= 0.
  - Else: `cont[i]`++.
  - Glitches shorter than DEBOUNCE cycles at `sinc` are rejected.
- **Undefined.** No counters or filter flops are built. `estavel` is `sinc`, and `DEBOUNCE` is ignored.

## Test plan
- **Reset release.** `rst` 0→1 with `entrada`=2'b01, `modo`=00, no debounce, defaults: exactly one `detector`=2'b01 pulse 3 edges after release; `pendente`=01; `contagem`=1.
- **Mode select.** With `modo`=01, drive `entrada[1]` 1→0 after it has been stable high: one pulse on `detector[1]`. Switch to `modo`=11 and toggle both inputs: `detector` stays 0 and `contagem` is unchanged. Return to 00: no spurious pulse.
- **Both edges and counter.**
  - `modo`=10, CNT_W=2, toggle `entrada[0]` every 2 cycles for 5 toggles: 5 pulses; `contagem` saturates at 3.
  - Then pulse `zera_cont` in the same cycle as an edge: `contagem`=0.
- **Pending-flag priority.** Assert `limpa[0]` on the same cycle `det_n[0]`=1: `pendente[0]` stays 1. Assert `limpa[0]` alone next cycle: `pendente[0]`=0.
- **Debounce.** With `DETECTOR_BORDA_DEBOUNCE_EN`, DEBOUNCE=4:
  - A 3-cycle high glitch on `entrada[0]` yields no pulse.
  - A 4-cycle high level yields one pulse 7 edges after E0.
- **Reset mid-operation.** Drop `rst` while a debounce count is at 2: all outputs read 0 immediately. After release with `entrada`=0, no pulse.
